// File: rtl/clk_recover_acq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_recover_acq_ctrl
// Purpose  : Acquisition and lock controller for the NCO-based clock-recovery
//            datapath. Sweeps the NCO frequency word over a programmed range,
//            clears the NCO phase on every step, scores rx-edge phases, and
//            declares / tracks / drops lock.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            enable          - run acquisition; low forces IDLE
//            edgeStrobe      - one-cycle pulse per detected rx transition
//            edgePhase       - NCO phase at that transition (two's complement)
//            freqWord        - frequency word to the NCO
//            ncoClear        - one-cycle NCO phase clear (coincides with LOAD)
//            locked          - lock status
//            sweepWrap       - pulse when the sweep wraps back to FREQ_MIN
//            lockLost        - pulse on the TRACK-to-LOAD transition
//            state           - IDLE=0, LOAD=1, DWELL=2, TRACK=3
// Revision : 1.0 - initial release
// ============================================================================
module clk_recover_acq_ctrl #(
    parameter int PHASE_WIDTH  = 16,
    parameter int FREQ_MIN     = 2,
    parameter int FREQ_MAX     = 64,
    parameter int FREQ_STEP    = 2,
    parameter int DWELL_EDGES  = 32,
    parameter int LOCK_COUNT   = 24,
    parameter int LOCK_THRESH  = 4096,
    parameter int UNLOCK_COUNT = 8,
    parameter int TIMEOUT      = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   edgeStrobe,
    input  logic [PHASE_WIDTH-1:0] edgePhase,
    output logic [PHASE_WIDTH-1:0] freqWord,
    output logic                   ncoClear,
    output logic                   locked,
    output logic                   sweepWrap,
    output logic                   lockLost,
    output logic [1:0]             state
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_DWELL = 2'd2;
    localparam logic [1:0] c_TRACK = 2'd3;

    localparam int c_EW = $clog2(DWELL_EDGES + 1);
    localparam int c_BW = $clog2(UNLOCK_COUNT + 1);
    localparam int c_IW = $clog2(TIMEOUT + 1);

    localparam logic [c_EW-1:0]        c_DWELL_EDGES  = c_EW'(DWELL_EDGES);
    localparam logic [c_EW-1:0]        c_LOCK_COUNT   = c_EW'(LOCK_COUNT);
    localparam logic [c_BW-1:0]        c_UNLOCK_COUNT = c_BW'(UNLOCK_COUNT);
    localparam logic [c_IW-1:0]        c_TIMEOUT      = c_IW'(TIMEOUT);
    localparam logic [c_IW-1:0]        c_TIMEOUT_M1   = c_IW'(TIMEOUT - 1);
    localparam logic [31:0]            c_LOCK_THRESH  = 32'(LOCK_THRESH);
    localparam logic [PHASE_WIDTH-1:0] c_FREQ_MIN     = PHASE_WIDTH'(FREQ_MIN);
    localparam logic [PHASE_WIDTH:0]   c_FREQ_MAX     = (PHASE_WIDTH+1)'(FREQ_MAX);
    localparam logic [PHASE_WIDTH:0]   c_FREQ_STEP    = (PHASE_WIDTH+1)'(FREQ_STEP);
    localparam logic [PHASE_WIDTH-1:0] c_MOST_NEG     = {1'b1, {(PHASE_WIDTH-1){1'b0}}};
    localparam logic [PHASE_WIDTH-1:0] c_MOST_POS     = {1'b0, {(PHASE_WIDTH-1){1'b1}}};

    logic [c_EW-1:0]        r_edge_cnt;
    logic [c_EW-1:0]        r_good_cnt;
    logic [c_BW-1:0]        r_bad_run;
    logic [c_IW-1:0]        r_idle_cnt;

    logic [PHASE_WIDTH-1:0] w_mag;
    logic                   w_good;
    logic                   w_timeout;
    logic [c_EW-1:0]        w_edge_next;
    logic [c_EW-1:0]        w_good_next;
    logic [c_BW-1:0]        w_bad_next;
    logic [PHASE_WIDTH:0]   w_step_sum;
    logic                   w_step_wrap;
    logic [PHASE_WIDTH-1:0] w_step_freq;

    // |edgePhase|; the most negative code has no positive twin, so it
    // saturates to the largest positive magnitude.
    always_comb begin
        w_mag = edgePhase;
        if (edgePhase == c_MOST_NEG) begin
            w_mag = c_MOST_POS;
        end else if (edgePhase[PHASE_WIDTH-1]) begin
            w_mag = -edgePhase;
        end
    end

    assign w_good      = (32'(w_mag) < c_LOCK_THRESH);
    // An edge arriving in the would-be timeout cycle keeps the signal alive.
    assign w_timeout   = (r_idle_cnt == c_TIMEOUT_M1) && !edgeStrobe;
    assign w_edge_next = r_edge_cnt + 1'b1;
    assign w_good_next = r_good_cnt + {{(c_EW-1){1'b0}}, w_good};
    assign w_bad_next  = r_bad_run + 1'b1;

    // Sweep step evaluated one bit wider so a step near full scale cannot
    // overflow past FREQ_MAX unnoticed.
    assign w_step_sum  = {1'b0, freqWord} + c_FREQ_STEP;
    assign w_step_wrap = (w_step_sum > c_FREQ_MAX);
    assign w_step_freq = w_step_wrap ? c_FREQ_MIN : w_step_sum[PHASE_WIDTH-1:0];

    // Loss-of-signal counter, saturating so it never wraps back below the
    // timeout point.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (edgeStrobe || state == c_IDLE || state == c_LOAD) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != c_TIMEOUT) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= c_IDLE;
            freqWord   <= c_FREQ_MIN;
            ncoClear   <= 1'b0;
            locked     <= 1'b0;
            sweepWrap  <= 1'b0;
            lockLost   <= 1'b0;
            r_edge_cnt <= '0;
            r_good_cnt <= '0;
            r_bad_run  <= '0;
        end else begin
            ncoClear  <= 1'b0;
            sweepWrap <= 1'b0;
            lockLost  <= 1'b0;
            if (!enable) begin
                state    <= c_IDLE;
                freqWord <= c_FREQ_MIN;
                locked   <= 1'b0;
            end else begin
                case (state)
                    c_IDLE: begin
                        freqWord <= c_FREQ_MIN;
                        locked   <= 1'b0;
                        state    <= c_LOAD;
                        ncoClear <= 1'b1;
                    end
                    c_LOAD: begin
                        r_edge_cnt <= '0;
                        r_good_cnt <= '0;
                        r_bad_run  <= '0;
                        state      <= c_DWELL;
                    end
                    c_DWELL: begin
                        if (edgeStrobe) begin
                            r_edge_cnt <= w_edge_next;
                            r_good_cnt <= w_good_next;
                            if (w_edge_next == c_DWELL_EDGES) begin
                                if (w_good_next >= c_LOCK_COUNT) begin
                                    state  <= c_TRACK;
                                    locked <= 1'b1;
                                end else begin
                                    state     <= c_LOAD;
                                    ncoClear  <= 1'b1;
                                    freqWord  <= w_step_freq;
                                    sweepWrap <= w_step_wrap;
                                end
                            end
                        end else if (w_timeout) begin
                            state     <= c_LOAD;
                            ncoClear  <= 1'b1;
                            freqWord  <= w_step_freq;
                            sweepWrap <= w_step_wrap;
                        end
                    end
                    default: begin // c_TRACK
                        if (edgeStrobe) begin
                            if (w_good) begin
                                r_bad_run <= '0;
                            end else begin
                                r_bad_run <= w_bad_next;
                                if (w_bad_next == c_UNLOCK_COUNT) begin
                                    state    <= c_LOAD;
                                    ncoClear <= 1'b1;
                                    locked   <= 1'b0;
                                    lockLost <= 1'b1;
                                end
                            end
                        end else if (w_timeout) begin
                            state    <= c_LOAD;
                            ncoClear <= 1'b1;
                            locked   <= 1'b0;
                            lockLost <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/clk_recover_acq_ctrl.md
Name: clk_recover_acq_ctrl

Overview:
- Acquisition and lock controller for the NCO-based serial clock-recovery datapath.
- Sweeps the NCO frequency word over a programmed range and clears the NCO phase at each step.
- Scores rx-edge phase samples returned by the datapath, then declares lock, tracks it, and re-acquires when lock is lost.
- Sits between receiver configuration/enable logic and the clock-recovery NCO.

Parameters:
- PHASE_WIDTH, 16: NCO phase and frequency word width.
- FREQ_MIN, 2: first and lowest frequency word in the sweep.
- FREQ_MAX, 64: highest frequency word in the sweep.
- FREQ_STEP, 2: sweep increment.
- DWELL_EDGES, 32: rx edges evaluated per frequency step.
- LOCK_COUNT, 24: good edges per dwell needed to declare lock.
- LOCK_THRESH, 4096: an edge is good when |signed edgePhase| < LOCK_THRESH.
- UNLOCK_COUNT, 8: consecutive bad edges in TRACK that drop lock.
- TIMEOUT, 4096: clk cycles without an edge that count as loss of signal.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run acquisition; low forces IDLE
- edgeStrobe  in  1  one-cycle pulse when the datapath detects an rx transition
- edgePhase  in  PHASE_WIDTH  NCO phase captured at that transition, two's complement
- freqWord  out  PHASE_WIDTH  frequency word driven to the NCO
- ncoClear  out  1  one-cycle NCO phase clear
- locked  out  1  lock status
- sweepWrap  out  1  one-cycle pulse when the sweep wraps from FREQ_MAX back to FREQ_MIN
- lockLost  out  1  one-cycle pulse on the TRACK-to-LOAD transition
- state  out  2  current state: IDLE=0, LOAD=1, DWELL=2, TRACK=3

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, freqWord=FREQ_MIN, ncoClear=0, locked=0, sweepWrap=0, lockLost=0; all internal counters 0.
- Edge scoring: err = $signed(edgePhase); mag = |err|. When err = -2^(PHASE_WIDTH-1), mag saturates to 2^(PHASE_WIDTH-1)-1. good = (mag < LOCK_THRESH).
- idleCnt: cleared on every edgeStrobe and in IDLE/LOAD; otherwise increments and saturates at TIMEOUT. Timeout fires when idleCnt == TIMEOUT-1 and there is no edge that cycle. An edge in the same cycle wins.
- IDLE: freqWord=FREQ_MIN, locked=0. When enable=1, go to LOAD next cycle.
- LOAD: lasts exactly 1 cycle.
  - ncoClear=1 during this cycle.
  - edgeCnt, goodCnt and badRun are cleared.
  - edgeStrobe is ignored.
  - Next state is DWELL.
  - freqWord is already valid for the whole LOAD cycle.
- DWELL:
  - On each edgeStrobe, edgeCnt++ and goodCnt += good.
  - On the edge that makes edgeCnt == DWELL_EDGES, evaluate including that edge:
    - goodCnt >= LOCK_COUNT: go to TRACK; locked=1 from the first TRACK cycle.
    - Otherwise, step the frequency and go to LOAD.
  - Timeout: step the frequency and go to LOAD.
- Frequency step: if freqWord + FREQ_STEP > FREQ_MAX (compare at PHASE_WIDTH+1 bits, no overflow), then freqWord=FREQ_MIN and sweepWrap pulses in the same cycle that LOAD is entered. Otherwise freqWord += FREQ_STEP. The sweep repeats indefinitely.
- TRACK:
  - locked=1; freqWord is held.
  - Good edge: badRun=0. Bad edge: badRun++.
  - When badRun reaches UNLOCK_COUNT, or on timeout: go to LOAD at the same freqWord (no step), locked=0 from the LOAD cycle, lockLost pulses during the LOAD cycle.
- enable=0 in any state: IDLE next cycle, with locked=0 and freqWord=FREQ_MIN next cycle. No lockLost pulse.
- rst has priority over enable.
- rst mid-operation returns all outputs to their reset values on the next cycle.
- Sweep latency from a failed dwell: evaluating edge (cycle N) -> LOAD (N+1, ncoClear=1) -> DWELL (N+2).

Test Plan:
- Test parameters: PHASE_WIDTH=16, FREQ_MIN=2, FREQ_MAX=8, FREQ_STEP=2, DWELL_EDGES=8, LOCK_COUNT=6, LOCK_THRESH=4096, UNLOCK_COUNT=3, TIMEOUT=64.

1. Reset, then enable=1 -> cycle after enable: state=LOAD, ncoClear=1 for one cycle, freqWord=2; next cycle state=DWELL.
2. Sweep with wrap: every dwell gets 8 edges with edgePhase=0x4000 (bad) -> freqWord runs 2,4,6,8,2; sweepWrap pulses once at the 8->2 step; locked stays 0.
3. Lock at the boundary: at freqWord=4, send 6 edges at phase 0x0100 and 2 at 0x4000 -> TRACK, locked=1. Repeat with 5 good and 3 bad -> steps to 6, no lock.
4. Unlock: in TRACK, send bad, bad, good, bad, bad, bad -> lockLost and LOAD only after the final bad edge; freqWord unchanged; ncoClear=1.
5. Timeout and priority: in DWELL, no edges for 64 cycles -> freq step. Repeat with an edge landing on cycle 64 -> no step.
6. Saturation and control: edgePhase=0x8000 counts as bad. enable=0 during TRACK -> IDLE, locked=0, freqWord=2, no lockLost. rst asserted during DWELL -> all outputs at reset values.
